// File: rtl/lvds_rx_deser.sv
// 4-lane 7:1 LVDS receive deserializer with frame-marker word alignment and lock tracking.
// Optional differential p/n consistency checking is enabled by defining LVDS_RX_DIFF_CHECK_EN.
module lvds_rx_deser #(
  parameter logic [6:0]  SYNC_PATTERN = 7'b1100011,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned MISS_LIMIT   = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [3:0]  lvds_data_p,
  input  logic [3:0]  lvds_data_n,
  input  logic        frame_p,
  input  logic        frame_n,
  input  logic        fault_clear,
  output logic [27:0] data_out,
  output logic        data_valid,
  output logic        locked,
  output logic [4:0]  lane_fault
);

  localparam int unsigned CntW =
      $clog2(((LOCK_COUNT > MISS_LIMIT) ? LOCK_COUNT : MISS_LIMIT) + 1);
  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_COUNT - 1);
  localparam logic [CntW-1:0] MissLast = CntW'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e          r_state;
  logic [3:0][6:0] r_sr_data;
  logic [6:0]      r_sr_frame;
  logic [2:0]      r_bit_cnt;
  logic [CntW-1:0] r_match_cnt;
  logic [CntW-1:0] r_miss_cnt;
  logic [27:0]     r_data;
  logic            r_valid;
  logic            r_locked;

  logic w_frame_match;
  logic w_boundary;

  assign w_frame_match = (r_sr_frame == SYNC_PATTERN);
  assign w_boundary    = (r_bit_cnt == 3'd0);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state     <= StHunt;
      r_sr_data   <= '0;
      r_sr_frame  <= '0;
      r_bit_cnt   <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_sr_frame <= {r_sr_frame[5:0], frame_p};
      for (int k = 0; k < 4; k++) begin
        r_sr_data[k] <= {r_sr_data[k][5:0], lvds_data_p[k]};
      end
      r_bit_cnt <= (r_bit_cnt == 3'd6) ? 3'd0 : r_bit_cnt + 3'd1;
      r_valid   <= 1'b0;

      unique case (r_state)
        StHunt: begin
          // Sliding search: a match defines this cycle as the word boundary.
          if (w_frame_match) begin
            r_bit_cnt   <= 3'd1;
            r_match_cnt <= CntW'(1);
            if (LOCK_COUNT == 1) begin
              r_state    <= StLocked;
              r_locked   <= 1'b1;
              r_miss_cnt <= '0;
            end else begin
              r_state <= StVerify;
            end
          end
        end
        StVerify: begin
          if (w_boundary) begin
            if (w_frame_match) begin
              r_match_cnt <= r_match_cnt + CntW'(1);
              if (r_match_cnt == LockLast) begin
                r_state    <= StLocked;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end
            end else begin
              r_state <= StHunt;
            end
          end
        end
        StLocked: begin
          if (w_boundary) begin
            if (w_frame_match) begin
              r_data     <= r_sr_data;
              r_valid    <= 1'b1;
              r_miss_cnt <= '0;
            end else if (r_miss_cnt == MissLast) begin
              r_state    <= StHunt;
              r_locked   <= 1'b0;
              r_miss_cnt <= '0;
            end else begin
              r_miss_cnt <= r_miss_cnt + CntW'(1);
            end
          end
        end
        default: begin
          r_state  <= StHunt;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign locked     = r_locked;

`ifdef LVDS_RX_DIFF_CHECK_EN
  logic [4:0] r_lane_fault;
  logic [4:0] w_diff_eq;

  assign w_diff_eq = ~({frame_p, lvds_data_p} ^ {frame_n, lvds_data_n});

  // Clear wins over a fault seen in the same cycle.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_lane_fault <= '0;
    end else if (fault_clear) begin
      r_lane_fault <= '0;
    end else begin
      r_lane_fault <= r_lane_fault | w_diff_eq;
    end
  end

  assign lane_fault = r_lane_fault;
`else
  logic w_unused;

  assign w_unused   = ^{lvds_data_n, frame_n, fault_clear};
  assign lane_fault = '0;
`endif

endmodule

// File: tb/tb_lvds_rx_deser.sv
// Scoreboard bench for lvds_rx_deser: words expected to be emitted are queued at send time
// and a negedge monitor pops and compares them on every data_valid strobe.
module tb_lvds_rx_deser;

  localparam logic [6:0] Sync = 7'b1100011;
`ifdef LVDS_RX_DIFF_CHECK_EN
  localparam logic [4:0] FaultLane2 = 5'b00100;
`else
  localparam logic [4:0] FaultLane2 = 5'b00000;
`endif

  logic        clk_in = 1'b0;
  logic        reset;
  logic [3:0]  lvds_data_p;
  logic [3:0]  lvds_data_n;
  logic        frame_p;
  logic        frame_n;
  logic        fault_clear;
  logic [27:0] data_out;
  logic        data_valid;
  logic        locked;
  logic [4:0]  lane_fault;

  lvds_rx_deser dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .lvds_data_p (lvds_data_p),
    .lvds_data_n (lvds_data_n),
    .frame_p     (frame_p),
    .frame_n     (frame_n),
    .fault_clear (fault_clear),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .locked      (locked),
    .lane_fault  (lane_fault)
  );

  always #5 clk_in = ~clk_in;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [27:0] exp_q[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, expected no strobe (cycle %0d)", name, act, cyc);
  endtask

  task automatic idle();
    lvds_data_p = 4'h0;
    lvds_data_n = 4'hF;
    frame_p     = 1'b0;
    frame_n     = 1'b1;
  endtask

  // Drives the top nbits of each 7-bit lane word, MSB first, one bit per negedge.
  task automatic send_bits(input logic [27:0] d, input logic [6:0] f, input int nbits);
    for (int i = 6; i > 6 - nbits; i--) begin
      @(negedge clk_in);
      lvds_data_p = {d[21+i], d[14+i], d[7+i], d[i]};
      lvds_data_n = ~lvds_data_p;
      frame_p     = f[i];
      frame_n     = ~f[i];
    end
  endtask

  task automatic send_word(input logic [27:0] d, input logic [6:0] f, input bit expect_out);
    send_bits(d, f, 7);
    if (expect_out) exp_q.push_back(d);
  endtask

  // Monitor: scoreboard pops plus lock edge timestamps.
  logic prev_valid = 1'b0;
  logic prev_locked = 1'b0;
  int   rise_cyc = -1;
  int   fall_cyc = -1;
  int   first_valid_cyc = -1;
  int   n_rise = 0;
  int   n_fall = 0;

  always @(negedge clk_in) begin
    if (data_valid) begin
      check("valid_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) fail_now("unexpected_strobe", {4'h0, data_out});
      else check("data_out", {4'h0, data_out}, {4'h0, exp_q.pop_front()});
    end
    if (locked && !prev_locked) begin
      rise_cyc        <= cyc;
      n_rise          <= n_rise + 1;
      first_valid_cyc <= -1;
    end else if (data_valid && first_valid_cyc < 0) begin
      first_valid_cyc <= cyc;
    end
    if (!locked && prev_locked) begin
      fall_cyc <= cyc;
      n_fall   <= n_fall + 1;
    end
    prev_valid  <= data_valid;
    prev_locked <= locked;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int saved;
    reset       = 1'b0;
    fault_clear = 1'b0;
    idle();
    #2 reset = 1'b1;
    repeat (2) @(negedge clk_in);
    check("rst_data_out", {4'h0, data_out}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_lane_fault", {27'd0, lane_fault}, 32'd0);
    reset = 1'b0;

    // Clean lock: 4 sync words, match registered 2 cycles after s0's LSB drive.
    send_word(28'h0, Sync, 1'b0);
    t0 = cyc;
    repeat (3) send_word(28'h0, Sync, 1'b0);
    send_word(28'hA5C3F0E, Sync, 1'b1);
    send_word(28'hA5C3F0E, Sync, 1'b1);
    send_word(28'h0000001, Sync, 1'b1);
    send_word(28'h8000000, Sync, 1'b1);
    check("lock_latency", rise_cyc - (t0 + 2), 32'd21);
    check("first_valid_latency", first_valid_cyc - rise_cyc, 32'd7);

    // Single corrupted frame: lock held, that word not emitted.
    saved = n_fall;
    send_word(28'h1111111, 7'b0000000, 1'b0);
    send_word(28'hFFFFFFF, Sync, 1'b1);
    send_word(28'h1234567, Sync, 1'b1);
    check("hold_no_fall", n_fall, saved);
    check("hold_locked", {31'd0, locked}, 32'd1);

    // Two corrupted frames: lock drops one cycle after the second bad boundary.
    send_word(28'h2222222, 7'b0000000, 1'b0);
    send_word(28'h3333333, 7'b0000000, 1'b0);
    t0 = cyc;
    saved = n_rise;
    send_word(28'h0, Sync, 1'b0);
    check("loss_time", fall_cyc, t0 + 2);
    check("loss_locked", {31'd0, locked}, 32'd0);

    // Shift the stream 3 bits: VERIFY sees a bad boundary, HUNT relocks on the new alignment.
    send_bits(28'h0, 7'b0000000, 3);
    send_word(28'h0, Sync, 1'b0);
    t0 = cyc;
    send_word(28'h0, Sync, 1'b0);
    check("false_match_unlocked", {31'd0, locked}, 32'd0);
    repeat (2) send_word(28'h0, Sync, 1'b0);
    send_word(28'h5A5A5A5, Sync, 1'b1);
    send_word(28'h0F0F0F0, Sync, 1'b1);
    check("relock_latency", rise_cyc - (t0 + 2), 32'd21);
    check("relock_one_rise", n_rise, saved + 1);

    // Reset three bits into a word while locked.
    send_bits(28'h7777777, Sync, 3);
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    check("midrst_data_out", {4'h0, data_out}, 32'd0);
    check("midrst_data_valid", {31'd0, data_valid}, 32'd0);
    check("midrst_locked", {31'd0, locked}, 32'd0);
    idle();
    repeat (2) @(negedge clk_in);
    reset = 1'b0;

    // Differential fault on lane 2, then clear colliding with a lane 0 fault.
    @(negedge clk_in);
    lvds_data_p[2] = 1'b1;
    lvds_data_n[2] = 1'b1;
    @(negedge clk_in);
    idle();
    check("fault_set", {27'd0, lane_fault}, {27'd0, FaultLane2});
    repeat (3) @(negedge clk_in);
    check("fault_hold", {27'd0, lane_fault}, {27'd0, FaultLane2});
    fault_clear    = 1'b1;
    lvds_data_p[0] = 1'b1;
    lvds_data_n[0] = 1'b1;
    @(negedge clk_in);
    fault_clear = 1'b0;
    idle();
    check("fault_clear", {27'd0, lane_fault}, 32'd0);

    // Relock after reset; no strobe is expected before this.
    send_word(28'h0, Sync, 1'b0);
    t0 = cyc;
    repeat (3) send_word(28'h0, Sync, 1'b0);
    send_word(28'h6DB6DB6, Sync, 1'b1);
    send_word(28'h0C30C30, Sync, 1'b1);
    check("rst_relock_latency", rise_cyc - (t0 + 2), 32'd21);

    repeat (2) send_word(28'h4444444, 7'b0000000, 1'b0);
    send_bits(28'h0, 7'b0000000, 7);
    check("final_locked", {31'd0, locked}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
